timer_cmd_scheduler: RTL

- Command sequencer and event arbiter in front of the multi-channel timer block (NB_INTERFACES channels, each with start/capture/rst_capture/alarm controls).
- Accepts queued channel commands over a valid/ready port and converts them into single-cycle control pulses and alarm register writes.
- Returns captured counter values and round-robin-arbitrated alarm events on one valid/ready event port.

---
 rtl/timer_cmd_scheduler.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/timer_cmd_scheduler.sv
// timer_cmd_scheduler: queues timer channel commands into control pulses/alarm writes, returns capture and round-robin alarm events.
// Define TIMER_SCHED_MISS_CNT_EN to build the saturating missed-alarm counter (alarm_miss_cnt is 0 otherwise).
module timer_cmd_scheduler #(
    parameter int TIMER_BITWIDTH = 32,
    parameter int NB_INTERFACES  = 10,
    parameter int CHAN_W         = 4,
    parameter int CMD_DEPTH      = 4,
    parameter int CAPTURE_LAT    = 2
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    cmd_valid,
    output logic                                    cmd_ready,
    input  logic [2:0]                              cmd_op,
    input  logic [CHAN_W-1:0]                       cmd_chan,
    input  logic [TIMER_BITWIDTH-1:0]               cmd_data,
    output logic [NB_INTERFACES-1:0]                start,
    output logic [NB_INTERFACES-1:0]                capture,
    output logic [NB_INTERFACES-1:0]                rst_capture,
    output logic [NB_INTERFACES-1:0]                alarm_en,
    output logic [TIMER_BITWIDTH*NB_INTERFACES-1:0] alarm,
    input  logic [NB_INTERFACES-1:0]                alarm_out,
    input  logic [TIMER_BITWIDTH*NB_INTERFACES-1:0] captured,
    output logic                                    evt_valid,
    input  logic                                    evt_ready,
    output logic                                    evt_type,
    output logic [CHAN_W-1:0]                       evt_chan,
    output logic [TIMER_BITWIDTH-1:0]               evt_value,
    output logic                                    cmd_err,
    output logic [15:0]                             alarm_miss_cnt
);
    localparam int AW = $clog2(CMD_DEPTH);
    localparam int CW = $clog2(CAPTURE_LAT + 1);
    localparam logic [CHAN_W:0] NB_C = (CHAN_W+1)'(NB_INTERFACES);
    localparam logic [2:0] OP_NOP = 3'd0, OP_START = 3'd1, OP_CAPTURE = 3'd2, OP_RST_CAP = 3'd3, OP_ARM = 3'd4, OP_DISARM = 3'd5;
    localparam logic [1:0] S_IDLE = 2'd0, S_ISSUE = 2'd1, S_WAIT_CAP = 2'd2, S_RESP = 2'd3;

    logic [2:0]                f_op   [CMD_DEPTH];
    logic [CHAN_W-1:0]         f_chan [CMD_DEPTH];
    logic [TIMER_BITWIDTH-1:0] f_data [CMD_DEPTH];
    logic [AW:0]               wr_q, rd_q;
    logic                      rdy_q, full, empty, push, pop, bad;
    logic [2:0]                h_op, op_q;
    logic [CHAN_W-1:0]         h_chan, chan_q, rr_q, sel, evt_chan_q;
    logic [TIMER_BITWIDTH-1:0] data_q, resp_q, evt_value_q;
    logic [TIMER_BITWIDTH-1:0] alarm_q [NB_INTERFACES];
    logic [TIMER_BITWIDTH-1:0] cap_arr [NB_INTERFACES];
    logic [1:0]                state_q, state_d;
    logic [CW-1:0]             cnt_q;
    logic [NB_INTERFACES-1:0]  start_q, capture_q, rst_capture_q, en_q, aout_q, pend_q, pend_d;
    logic [NB_INTERFACES-1:0]  oh, sel_oh, arm_m, dis_m, rise;
    logic                      issue, cap_done, can_load, load_cap, load_alm, found;
    logic                      evt_valid_q, evt_type_q, err_q;
    int                        j;

    for (genvar i = 0; i < NB_INTERFACES; i++) begin : g_ch
        assign alarm[i*TIMER_BITWIDTH +: TIMER_BITWIDTH] = alarm_q[i];
        assign cap_arr[i] = captured[i*TIMER_BITWIDTH +: TIMER_BITWIDTH];
    end

    assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty     = wr_q == rd_q;
    assign cmd_ready = rdy_q && !full;
    assign push      = cmd_valid && cmd_ready;
    assign pop       = state_q == S_IDLE && !empty;
    assign h_op      = f_op[rd_q[AW-1:0]];
    assign h_chan    = f_chan[rd_q[AW-1:0]];
    assign bad       = h_op > OP_DISARM || {1'b0, h_chan} >= NB_C;

    assign issue    = state_q == S_ISSUE;
    assign oh       = NB_INTERFACES'(1) << chan_q;
    assign sel_oh   = NB_INTERFACES'(1) << sel;
    assign arm_m    = issue && op_q == OP_ARM ? oh : '0;
    assign dis_m    = issue && op_q == OP_DISARM ? oh : '0;
    assign cap_done = state_q == S_WAIT_CAP && cnt_q == CW'(CAPTURE_LAT - 1);
    assign can_load = !evt_valid_q || evt_ready;
    assign load_cap = can_load && state_q == S_RESP;
    assign load_alm = can_load && !load_cap && |pend_q;
    // registered edge detect; DISARM is applied last so it beats a same-cycle edge
    assign rise     = alarm_out & ~aout_q & en_q;
    assign pend_d   = ((pend_q & ~(load_alm ? sel_oh : '0)) | rise) & ~dis_m;

    assign state_d = state_q == S_IDLE ? (pop && !bad && h_op != OP_NOP ? S_ISSUE : S_IDLE)
                   : state_q == S_ISSUE ? (op_q == OP_CAPTURE ? S_WAIT_CAP : S_IDLE)
                   : state_q == S_WAIT_CAP ? (cap_done ? S_RESP : S_WAIT_CAP)
                   : (load_cap ? S_IDLE : S_RESP);

    always_comb begin
        sel = '0;
        found = 1'b0;
        j = 0;
        for (int i = 0; i < NB_INTERFACES; i++) begin
            j = int'(rr_q) + i;
            j = j >= NB_INTERFACES ? j - NB_INTERFACES : j;
            if (!found && pend_q[j]) begin
                sel = CHAN_W'(j);
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            f_op[wr_q[AW-1:0]]   <= cmd_op;
            f_chan[wr_q[AW-1:0]] <= cmd_chan;
            f_data[wr_q[AW-1:0]] <= cmd_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdy_q         <= 1'b0;
            wr_q          <= '0;
            rd_q          <= '0;
            state_q       <= S_IDLE;
            op_q          <= '0;
            chan_q        <= '0;
            data_q        <= '0;
            cnt_q         <= '0;
            resp_q        <= '0;
            start_q       <= '0;
            capture_q     <= '0;
            rst_capture_q <= '0;
            en_q          <= '0;
            aout_q        <= '0;
            pend_q        <= '0;
            rr_q          <= '0;
            evt_valid_q   <= 1'b0;
            evt_type_q    <= 1'b0;
            evt_chan_q    <= '0;
            evt_value_q   <= '0;
            err_q         <= 1'b0;
            for (int i = 0; i < NB_INTERFACES; i++) alarm_q[i] <= '0;
        end else begin
            rdy_q         <= 1'b1;
            wr_q          <= wr_q + (AW+1)'(push);
            rd_q          <= rd_q + (AW+1)'(pop);
            state_q       <= state_d;
            cnt_q         <= state_q == S_WAIT_CAP ? cnt_q + CW'(1) : '0;
            start_q       <= issue && op_q == OP_START ? oh : '0;
            capture_q     <= issue && op_q == OP_CAPTURE ? oh : '0;
            rst_capture_q <= issue && op_q == OP_RST_CAP ? oh : '0;
            en_q          <= (en_q | arm_m) & ~dis_m;
            aout_q        <= alarm_out;
            pend_q        <= pend_d;
            for (int i = 0; i < NB_INTERFACES; i++) if (arm_m[i]) alarm_q[i] <= data_q;
            if (pop) begin
                op_q   <= h_op;
                chan_q <= h_chan;
                data_q <= f_data[rd_q[AW-1:0]];
            end
            if (pop && bad) err_q <= 1'b1;
            if (cap_done) resp_q <= cap_arr[chan_q];
            if (load_cap) begin
                evt_valid_q <= 1'b1;
                evt_type_q  <= 1'b1;
                evt_chan_q  <= chan_q;
                evt_value_q <= resp_q;
            end else if (load_alm) begin
                evt_valid_q <= 1'b1;
                evt_type_q  <= 1'b0;
                evt_chan_q  <= sel;
                evt_value_q <= alarm_q[sel];
                rr_q        <= int'(sel) == NB_INTERFACES - 1 ? '0 : sel + CHAN_W'(1);
            end else if (evt_ready) begin
                evt_valid_q <= 1'b0;
            end
        end
    end

`ifdef TIMER_SCHED_MISS_CNT_EN
    logic [15:0] miss_q;
    always_ff @(posedge clk) begin
        if (rst) miss_q <= '0;
        else if (|(rise & pend_q) && miss_q != 16'hFFFF) miss_q <= miss_q + 16'd1;
    end
    assign alarm_miss_cnt = miss_q;
`else
    assign alarm_miss_cnt = '0;
`endif

    assign start       = start_q;
    assign capture     = capture_q;
    assign rst_capture = rst_capture_q;
    assign alarm_en    = en_q;
    assign evt_valid   = evt_valid_q;
    assign evt_type    = evt_type_q;
    assign evt_chan    = evt_chan_q;
    assign evt_value   = evt_value_q;
    assign cmd_err     = err_q;
endmodule
